// File: rtl/ysyx_220053_exu_ctrl_pkg.sv
// Shared types and constants for the EXU execute sequencer.
package ysyx_220053_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_WAIT_MDU = 2'd2,
        S_WB       = 2'd3
    } state_e;

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_MUL = 2'd1;
    localparam logic [1:0] CLS_DIV = 2'd2;
    localparam logic [1:0] CLS_RSV = 2'd3;

    localparam int MDU_TIMEOUT_DEF = 127;
    localparam int TOCNT_W         = 7;

    function automatic logic is_mdu(input logic [1:0] cls);
        return (cls == CLS_MUL) || (cls == CLS_DIV);
    endfunction

endpackage

// File: rtl/ysyx_220053_exu_ctrl_if.sv
// Bundle of IDU, datapath, MDU and write-back signals seen by the execute sequencer.
interface ysyx_220053_exu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_wen;
    logic        in_alusrcb;
    logic [1:0]  in_cls;
    logic        flush;
    logic [4:0]  rf_raddr_a;
    logic [4:0]  rf_raddr_b;
    logic        alusrcb;
    logic        mdu_start;
    logic        mdu_is_div;
    logic        mdu_done;
    logic        mdu_kill;
    logic        wb_sel;
    logic        wb_valid;
    logic        wb_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic        mdu_err;
    logic [31:0] retire_cnt;

    modport master (
        output in_valid, in_rd, in_rs1, in_rs2, in_wen, in_alusrcb, in_cls,
               flush, mdu_done, wb_ready,
        input  in_ready, rf_raddr_a, rf_raddr_b, alusrcb, mdu_start, mdu_is_div,
               mdu_kill, wb_sel, wb_valid, rf_wen, rf_waddr, mdu_err, retire_cnt
    );

    modport slave (
        input  in_valid, in_rd, in_rs1, in_rs2, in_wen, in_alusrcb, in_cls,
               flush, mdu_done, wb_ready,
        output in_ready, rf_raddr_a, rf_raddr_b, alusrcb, mdu_start, mdu_is_div,
               mdu_kill, wb_sel, wb_valid, rf_wen, rf_waddr, mdu_err, retire_cnt
    );
endinterface

// File: rtl/ysyx_220053_exu_ctrl_tocnt.sv
// Clearable saturating timeout counter; hit stays high while the count sits at LIMIT.
module ysyx_220053_tocnt
    import ysyx_220053_pkg::*;
#(
    parameter int LIMIT = MDU_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_hit
);

    logic [TOCNT_W-1:0] r_cnt;

    assign o_hit = (r_cnt == TOCNT_W'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (!o_hit) begin
            r_cnt <= r_cnt + TOCNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_220053_exu_ctrl.sv
// Multi-cycle execute sequencer: accepts one decoded instruction, steers the EXU/MDU,
// and issues a single qualified register-file write after the write-back handshake.
module ysyx_220053_exu_ctrl
    import ysyx_220053_pkg::*;
#(
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ysyx_220053_exu_ctrl_if.slave   bus
);

    state_e      r_state;
    state_e      w_next;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic        r_wen;
    logic        r_alusrcb;
    logic [1:0]  r_cls;
    logic        r_supp;
    logic        r_err;
    logic [31:0] r_retire;

    logic        w_accept;
    logic        w_hit;
    logic        w_mdu;
    logic        w_timeout;
    logic        w_wb_fire;
    logic        w_busy;

    assign w_mdu     = is_mdu(r_cls);
    assign w_busy    = (r_state != S_IDLE);
    assign w_accept  = (r_state == S_IDLE) && bus.in_valid && !bus.flush;
    assign w_timeout = (r_state == S_WAIT_MDU) && w_hit && !bus.mdu_done && !bus.flush;
    assign w_wb_fire = (r_state == S_WB) && bus.wb_ready && !bus.flush;

    // Counter is held clear outside WAIT_MDU, so it reads zero on the first wait cycle.
    ysyx_220053_tocnt #(.LIMIT(MDU_TIMEOUT)) u_tocnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state != S_WAIT_MDU),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (w_accept) w_next = S_EXEC;
            S_EXEC:     w_next = w_mdu ? S_WAIT_MDU : S_WB;
            S_WAIT_MDU: if (bus.mdu_done || w_hit) w_next = S_WB;
            S_WB:       if (bus.wb_ready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    // Reserved class executes as ALU but never writes back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_wen     <= 1'b0;
            r_alusrcb <= 1'b0;
            r_cls     <= CLS_ALU;
            r_supp    <= 1'b0;
            r_err     <= 1'b0;
            r_retire  <= '0;
        end else begin
            if (w_accept) begin
                r_rd      <= bus.in_rd;
                r_rs1     <= bus.in_rs1;
                r_rs2     <= bus.in_rs2;
                r_wen     <= bus.in_wen && (bus.in_cls != CLS_RSV);
                r_alusrcb <= bus.in_alusrcb;
                r_cls     <= bus.in_cls;
                r_supp    <= 1'b0;
            end
            if (w_timeout) begin
                r_supp <= 1'b1;
                r_err  <= 1'b1;
            end
            if (w_wb_fire) r_retire <= r_retire + 32'd1;
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.rf_raddr_a = w_busy ? r_rs1 : 5'd0;
    assign bus.rf_raddr_b = w_busy ? r_rs2 : 5'd0;
    assign bus.alusrcb    = w_busy && r_alusrcb;
    assign bus.mdu_start  = (r_state == S_EXEC) && w_mdu;
    assign bus.mdu_is_div = (r_state == S_EXEC) && (r_cls == CLS_DIV);
    assign bus.mdu_kill   = (r_state == S_WAIT_MDU) && (bus.flush || (w_hit && !bus.mdu_done));
    assign bus.wb_valid   = (r_state == S_WB);
    assign bus.wb_sel     = (r_state == S_WB) && w_mdu;
    assign bus.rf_waddr   = (r_state == S_WB) ? r_rd : 5'd0;
    assign bus.rf_wen     = w_wb_fire && r_wen && (r_rd != 5'd0) && !r_supp;
    assign bus.mdu_err    = r_err;
    assign bus.retire_cnt = r_retire;

endmodule

// File: tb/tb_ysyx_220053_exu_ctrl.sv
// Directed bench for the execute sequencer with a per-instruction timeline model.
module tb_ysyx_220053_exu_ctrl;

    localparam int TO = 127;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errs   = 0;

    ysyx_220053_exu_ctrl_if itf();

    ysyx_220053_exu_ctrl #(.MDU_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (itf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish, need finish");
        $fatal(1, "timeout");
    end

    // Expected values for the current cycle, set by the driver.
    logic        chk_en = 1'b0;
    logic        e_in_ready, e_alusrcb, e_start, e_div, e_kill;
    logic        e_wb_valid, e_wb_sel, e_rf_wen, e_err;
    logic [4:0]  e_ra, e_rb, e_waddr;
    logic [31:0] e_retire;

    logic [31:0] m_ret = 0;
    logic        m_err = 1'b0;
    int wen_cyc, start_cyc, wb_cyc, kill_cyc;
    logic [4:0] waddr_at_wen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, need %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",   32'(itf.in_ready),   32'(e_in_ready));
            chk("rf_raddr_a", 32'(itf.rf_raddr_a), 32'(e_ra));
            chk("rf_raddr_b", 32'(itf.rf_raddr_b), 32'(e_rb));
            chk("alusrcb",    32'(itf.alusrcb),    32'(e_alusrcb));
            chk("mdu_start",  32'(itf.mdu_start),  32'(e_start));
            chk("mdu_is_div", 32'(itf.mdu_is_div), 32'(e_div));
            chk("mdu_kill",   32'(itf.mdu_kill),   32'(e_kill));
            chk("wb_valid",   32'(itf.wb_valid),   32'(e_wb_valid));
            chk("wb_sel",     32'(itf.wb_sel),     32'(e_wb_sel));
            chk("rf_wen",     32'(itf.rf_wen),     32'(e_rf_wen));
            chk("rf_waddr",   32'(itf.rf_waddr),   32'(e_waddr));
            chk("mdu_err",    32'(itf.mdu_err),    32'(e_err));
            chk("retire_cnt", itf.retire_cnt,      e_retire);
        end
    end

    task automatic idle_inputs();
        itf.in_valid = 1'b0; itf.in_rd = 5'd0; itf.in_rs1 = 5'd0; itf.in_rs2 = 5'd0;
        itf.in_wen = 1'b0; itf.in_alusrcb = 1'b0; itf.in_cls = 2'd0;
        itf.flush = 1'b0; itf.mdu_done = 1'b0; itf.wb_ready = 1'b0;
    endtask

    // k: cycle of mdu_done (-1 none); rdly: wb_ready low cycles in WB; f: flush cycle (-1 none).
    // Cycle 0 is the accept cycle; the task starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input logic [1:0] cls, input logic [4:0] rd, rs1, rs2,
                           input logic wen, asb, input int k, rdly, f);
        bit mdu, to, fl;
        int w, fin, last, pc;
        mdu  = (cls == 2'd1) || (cls == 2'd2);
        to   = mdu && (k < 2);
        w    = !mdu ? 2 : (to ? TO + 3 : k + 1);
        fin  = w + rdly;
        fl   = (f >= 1);
        if (fl) fin = f;
        last = ((k > fin) ? k : fin) + 2;
        wen_cyc = -1; start_cyc = -1; wb_cyc = -1; kill_cyc = -1; waddr_at_wen = 5'd0;
        for (int c = 0; c <= last; c++) begin
            pc = (c == 0 || c > fin) ? 0 : (c == 1) ? 1 : (c < w) ? 2 : 3;
            itf.in_valid = (c == 0); itf.in_rd = rd; itf.in_rs1 = rs1; itf.in_rs2 = rs2;
            itf.in_wen = wen; itf.in_alusrcb = asb; itf.in_cls = cls;
            itf.mdu_done = (c == k);
            itf.flush    = fl && (c == f);
            itf.wb_ready = (c >= w + rdly);
            e_in_ready = (pc == 0);
            e_ra       = (pc != 0) ? rs1 : 5'd0;
            e_rb       = (pc != 0) ? rs2 : 5'd0;
            e_alusrcb  = (pc != 0) && asb;
            e_start    = (pc == 1) && mdu;
            e_div      = (pc == 1) && (cls == 2'd2);
            e_kill     = (pc == 2) && ((fl && c == f) || (to && c == TO + 2));
            e_wb_valid = (pc == 3);
            e_wb_sel   = (pc == 3) && mdu;
            e_waddr    = (pc == 3) ? rd : 5'd0;
            e_rf_wen   = (pc == 3) && (c == fin) && !fl && wen && (rd != 0) && (cls != 2'd3) && !to;
            e_err      = m_err | (to && (!fl || f > TO + 2) && c >= TO + 3);
            e_retire   = m_ret + ((!fl && c > fin) ? 32'd1 : 32'd0);
            chk_en = 1'b1;
            @(negedge clk);
            if (itf.rf_wen && wen_cyc < 0) begin wen_cyc = c; waddr_at_wen = itf.rf_waddr; end
            if (itf.mdu_start && start_cyc < 0) start_cyc = c;
            if (itf.wb_valid && wb_cyc < 0) wb_cyc = c;
            if (itf.mdu_kill && kill_cyc < 0) kill_cyc = c;
            @(posedge clk); #1;
        end
        chk_en = 1'b0;
        if (!fl) m_ret = m_ret + 32'd1;
        if (to && (!fl || f > TO + 2)) m_err = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", 32'(itf.in_ready), 32'd1);
        chk("rst_wb_valid", 32'(itf.wb_valid), 32'd0);
        chk("rst_retire",   itf.retire_cnt,    32'd0);
        chk("rst_err",      32'(itf.mdu_err),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU, rd=5
        run_txn(2'd0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, -1, 0, -1);
        chk("alu_wen_cycle", wen_cyc, 2);
        chk("alu_waddr",     32'(waddr_at_wen), 32'd5);
        chk("alu_retire",    itf.retire_cnt, 32'd1);

        // rd=0 never writes but still retires
        run_txn(2'd0, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, -1, 0, -1);
        chk("rd0_wen_cycle", wen_cyc, -1);
        chk("rd0_retire",    itf.retire_cnt, 32'd2);

        // MUL, done in cycle 4, wb_ready held low 3 cycles
        run_txn(2'd1, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0, 4, 3, -1);
        chk("mul_start_cycle", start_cyc, 1);
        chk("mul_wb_cycle",    wb_cyc, 5);
        chk("mul_wen_cycle",   wen_cyc, 8);

        // DIV with no done: timeout
        run_txn(2'd2, 5'd9, 5'd10, 5'd11, 1'b1, 1'b1, -1, 0, -1);
        chk("div_kill_cycle", kill_cyc, TO + 2);
        chk("div_wen_cycle",  wen_cyc, -1);
        chk("div_err",        32'(itf.mdu_err), 32'd1);
        chk("div_retire",     itf.retire_cnt, 32'd4);

        // MUL flushed in WAIT_MDU, late done ignored
        run_txn(2'd1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 6, 0, 4);
        chk("flush_kill_cycle", kill_cyc, 4);
        chk("flush_retire",     itf.retire_cnt, 32'd4);
        chk("flush_err_sticky", 32'(itf.mdu_err), 32'd1);

        // Reserved class, ALU flushed in EXEC and in WB, DIV with immediate done
        run_txn(2'd3, 5'd3, 5'd1, 5'd1, 1'b1, 1'b0, -1, 0, -1);
        run_txn(2'd0, 5'd6, 5'd2, 5'd7, 1'b1, 1'b1, -1, 0, 1);
        run_txn(2'd0, 5'd6, 5'd2, 5'd7, 1'b1, 1'b0, -1, 0, 2);
        run_txn(2'd2, 5'd15, 5'd16, 5'd17, 1'b1, 1'b0, 2, 1, -1);
        chk("div2_wen_cycle", wen_cyc, 4);
        chk("div2_retire",    itf.retire_cnt, 32'd6);

        // flush in IDLE blocks acceptance
        itf.in_valid = 1'b1; itf.flush = 1'b1; itf.in_rs1 = 5'd21; itf.in_cls = 2'd0;
        @(posedge clk); #1;
        idle_inputs();
        chk("idle_flush_ready", 32'(itf.in_ready),   32'd1);
        chk("idle_flush_ra",    32'(itf.rf_raddr_a), 32'd0);

        // async reset in WB with wb_ready low
        itf.in_valid = 1'b1; itf.in_rd = 5'd4; itf.in_rs1 = 5'd5; itf.in_wen = 1'b1;
        @(posedge clk); #1;
        itf.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_wb_valid", 32'(itf.wb_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wb_valid", 32'(itf.wb_valid),   32'd0);
        chk("arst_in_ready", 32'(itf.in_ready),   32'd1);
        chk("arst_ra",       32'(itf.rf_raddr_a), 32'd0);
        chk("arst_waddr",    32'(itf.rf_waddr),   32'd0);
        chk("arst_rf_wen",   32'(itf.rf_wen),     32'd0);
        chk("arst_retire",   itf.retire_cnt,      32'd0);
        chk("arst_err",      32'(itf.mdu_err),    32'd0);
        idle_inputs();
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(itf.in_ready), 32'd1);
        @(posedge clk); #1;
        m_ret = 32'd0; m_err = 1'b0;
        run_txn(2'd0, 5'd31, 5'd30, 5'd29, 1'b1, 1'b0, -1, 0, -1);
        chk("post_rst_retire", itf.retire_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/ysyx_220053_exu_ctrl.md
# ysyx_220053_exu_ctrl

Multi-cycle execute sequencer for the EXU datapath (register file + ALU/adder + operand-B mux) and the shared multiply/divide unit (MDU). It accepts one decoded instruction at a time from the IDU over a valid/ready handshake, drives the register-file read addresses, operand-B select and MDU start, and issues exactly one qualified register-file write per instruction after a write-back handshake. It sits between the IDU and the EXU datapath and replaces the fixed single-cycle `wen` wiring.

## Interface
- `MDU_TIMEOUT`, default 127: maximum WAIT_MDU cycles before abort.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: IDU has a decoded instruction.
- `in_ready` out 1: controller can accept (IDLE only).
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_wen` in 1: instruction writes `rd`.
- `in_alusrcb` in 1: operand B is the immediate (1) or `rs2` (0).
- `in_cls` in 2: 0 ALU, 1 MUL, 2 DIV, 3 reserved (treated as ALU, `wen` forced 0).
- `flush` in 1: synchronous kill of the in-flight instruction.
- `rf_raddr_a`, `rf_raddr_b` out 5 each: register-file read addresses.
- `alusrcb` out 1: operand-B mux select.
- `mdu_start` out 1: one-cycle MDU start pulse.
- `mdu_is_div` out 1: MDU op select, valid with `mdu_start`.
- `mdu_done` in 1: MDU result valid, single-cycle pulse.
- `mdu_kill` out 1: abort the MDU.
- `wb_sel` out 1: write-back source, 0 ALU, 1 MDU.
- `wb_valid` out 1: write-back pending.
- `wb_ready` in 1: write-back accepted this cycle.
- `rf_wen` out 1: register-file write enable.
- `rf_waddr` out 5: write address.
- `mdu_err` out 1: sticky MDU timeout flag.
- `retire_cnt` out 32: wrapping count of completed write-back handshakes.

## Operation
- States: IDLE, EXEC, WAIT_MDU, WB. Moore outputs decode from state and latched fields only.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, latch rd/rs1/rs2/wen/alusrcb/cls and go to EXEC.
- EXEC, one cycle: `rf_raddr_a`/`rf_raddr_b`/`alusrcb` drive latched values. ALU class goes to WB. MUL/DIV asserts `mdu_start` (`mdu_is_div` = cls==DIV) and goes to WAIT_MDU. Read addresses hold latched values in all non-IDLE states and are 0 in IDLE.
- WAIT_MDU: a 7-bit counter cleared on entry increments each cycle. `mdu_done` goes to WB. If the counter reaches `MDU_TIMEOUT` without `mdu_done`: set `mdu_err`, pulse `mdu_kill`, go to WB with the write suppressed.
- WB: `wb_valid`=1. `wb_sel`=1 for MUL/DIV. `rf_waddr`=latched rd.
  - `rf_wen` = `wb_valid & wb_ready & wen & (rd!=0) & !suppressed`.
  - Stay in WB until `wb_ready`, then increment `retire_cnt` and go to IDLE.
- `flush` has priority over all other transitions. Any non-IDLE state goes to IDLE next cycle with `rf_wen`=0 in the flush cycle and `retire_cnt` unchanged. `mdu_kill`=1 that cycle if in WAIT_MDU. `flush` in IDLE blocks acceptance that cycle.
- `mdu_done` outside WAIT_MDU is ignored.
- `mdu_err` clears only on reset.

## Timing
- Reset, asynchronous: state IDLE, `in_ready`=1. All other outputs, the latches, the counter, `mdu_err` and `retire_cnt` are 0.
- ALU instruction with `wb_ready` tied 1: accept at edge 0, EXEC cycle 1, WB cycle 2 (`rf_wen` high), `in_ready` high cycle 3. Throughput is 1 instruction per 3 cycles.
- MDU instruction: `mdu_start` in cycle 1. `mdu_done` in cycle k moves to WB in cycle k+1.
- Reset asserted mid-operation: immediate return to the reset values with no write.

## Structure
- Shared package `ysyx_220053_pkg`: state enum, `in_cls` encodings (ALU/MUL/DIV/RSV), `MDU_TIMEOUT` default.
- One sub-module, `ysyx_220053_tocnt`: clearable saturating timeout counter with a `hit` output. All other logic stays in the FSM module.

## Test plan
- ALU op: rd=5, wen=1, wb_ready=1. Required: `rf_wen`=1 with `rf_waddr`=5 exactly in cycle 2, `in_ready`=1 in cycle 3, `retire_cnt`=1.
- rd=0 with wen=1. Required: `wb_valid` handshake completes, `rf_wen` never asserts, `retire_cnt` increments.
- MUL op, `mdu_done` in cycle 4. Required: `mdu_start` only in cycle 1 with `mdu_is_div`=0, WB in cycle 5 with `wb_sel`=1. Hold `wb_ready`=0 for 3 cycles: `rf_wen` stays 0 until the ready cycle.
- DIV op, `mdu_done` never arrives. Required: after `MDU_TIMEOUT` cycles, `mdu_kill` pulses, `mdu_err`=1 and stays sticky, WB completes with `rf_wen`=0.
- `flush` in WAIT_MDU. Required: `mdu_kill`=1 that cycle, IDLE next cycle, no `rf_wen`, `retire_cnt` unchanged. A later `mdu_done` pulse is ignored.
- `rst_n` low during WB with `wb_ready`=0. Required: outputs reach reset values asynchronously, and `in_ready`=1 once reset is released.
